// File: rtl/bus_slot_scheduler.sv
// Time-division owner of the shared RAM bus: a fixed frame with reserved video
// and CPU slots, guard cycles between owners, and a free window that is lent to
// Wishbone only when a worst-case transaction fits before the next guard.
module bus_slot_scheduler #(
    parameter int unsigned FRAME_CYCLES  = 64,
    parameter int unsigned VIDEO_CYCLES  = 8,
    parameter int unsigned CPU_CYCLES    = 8,
    parameter int unsigned WB_MAX_CYCLES = 8
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            wb_req_i,
    input  logic                            wb_done_i,
    output logic                            video_grant_o,
    output logic                            cpu_grant_o,
    output logic                            wb_grant_o,
    output logic                            video_strobe_o,
    output logic                            cpu_strobe_o,
    output logic                            overrun_o,
    output logic [$clog2(FRAME_CYCLES)-1:0] slot_count_o
);

    localparam int unsigned CountWidth = $clog2(FRAME_CYCLES);

    localparam logic [CountWidth-1:0] FrameLast = CountWidth'(FRAME_CYCLES - 1);
    localparam logic [CountWidth-1:0] VideoLast = CountWidth'(VIDEO_CYCLES - 1);
    localparam logic [CountWidth-1:0] CpuFirst  = CountWidth'(VIDEO_CYCLES + 1);
    localparam logic [CountWidth-1:0] CpuLast   = CountWidth'(VIDEO_CYCLES + CPU_CYCLES);
    localparam logic [CountWidth-1:0] WinFirst  = CountWidth'(VIDEO_CYCLES + CPU_CYCLES + 2);
    // Latest start that still lets a worst-case transaction end before the last guard.
    localparam logic [CountWidth-1:0] StartLast = CountWidth'(FRAME_CYCLES - 1 - WB_MAX_CYCLES);

    if (VIDEO_CYCLES + CPU_CYCLES + 2 + WB_MAX_CYCLES > FRAME_CYCLES - 1) begin : g_param_check
        $fatal(1, "bus_slot_scheduler: slots do not fit in FRAME_CYCLES");
    end

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StTurn
    } wb_state_e;

    wb_state_e             wb_state_q, wb_state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  video_grant_q, video_grant_d;
    logic                  cpu_grant_q, cpu_grant_d;
    logic                  video_strobe_q, video_strobe_d;
    logic                  cpu_strobe_q, cpu_strobe_d;
    logic                  overrun_q, overrun_d;
    logic                  start_ok;

    // Frame counter and reserved-slot decode for the cycle about to be entered.
    always_comb begin
        count_d = (count_q == FrameLast) ? '0 : count_q + 1'b1;
        // Video is armed only by a wrap to 0, so a partial first frame never
        // hands the bus to video mid-slot.
        video_grant_d  = (count_d == '0) | ((count_d <= VideoLast) & video_grant_q);
        video_strobe_d = video_grant_d & (count_d == VideoLast);
        cpu_grant_d    = (count_d >= CpuFirst) & (count_d <= CpuLast);
        cpu_strobe_d   = (count_d == CpuLast);
        start_ok       = (count_d >= WinFirst) & (count_d <= StartLast);
    end

    // Wishbone ownership: grant, one turnaround cycle, forced revoke at frame end.
    always_comb begin
        wb_state_d = wb_state_q;
        overrun_d  = overrun_q;
        unique case (wb_state_q)
            StIdle: begin
                if (wb_req_i && start_ok) begin
                    wb_state_d = StGrant;
                end
            end
            StGrant: begin
                if (wb_done_i) begin
                    wb_state_d = StTurn;
                end else if (count_d == FrameLast) begin
                    wb_state_d = StIdle;
                    overrun_d  = 1'b1;
                end
            end
            StTurn: begin
                // The turnaround cycle itself is the gap; a waiting request may follow it.
                wb_state_d = (wb_req_i && start_ok) ? StGrant : StIdle;
            end
            default: begin
                wb_state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset drops every grant without a clock edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q        <= '0;
            video_grant_q  <= 1'b0;
            cpu_grant_q    <= 1'b0;
            video_strobe_q <= 1'b0;
            cpu_strobe_q   <= 1'b0;
            overrun_q      <= 1'b0;
            wb_state_q     <= StIdle;
        end else begin
            count_q        <= count_d;
            video_grant_q  <= video_grant_d;
            cpu_grant_q    <= cpu_grant_d;
            video_strobe_q <= video_strobe_d;
            cpu_strobe_q   <= cpu_strobe_d;
            overrun_q      <= overrun_d;
            wb_state_q     <= wb_state_d;
        end
    end

    assign slot_count_o   = count_q;
    assign video_grant_o  = video_grant_q;
    assign cpu_grant_o    = cpu_grant_q;
    assign video_strobe_o = video_strobe_q;
    assign cpu_strobe_o   = cpu_strobe_q;
    assign overrun_o      = overrun_q;
    assign wb_grant_o     = (wb_state_q == StGrant);

endmodule
